// File: rtl/tt_capture.sv
// Truth-table capture engine: sweeps vec 0..15 into a combinational gate and
// records gate_out per vector. Optional reference compare under `TT_COMPARE_EN.
module tt_capture #(
  parameter int SETTLE = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        abort,
  output logic [3:0]  vec,
  input  logic        gate_out,
  output logic        busy,
  output logic        done,
  output logic [15:0] tt
`ifdef TT_COMPARE_EN
  ,
  input  logic [15:0] expect_tt,
  output logic        match
`endif
);

  typedef enum logic [1:0] {IDLE, DRIVE, SAMPLE, DONE} state_t;

  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE - 1);

  state_t      state_reg, state_next;
  logic [3:0]  settle_cnt_reg;
  logic [15:0] work_reg;
  logic [15:0] sweep_result;

  // The last vector's sample joins the working bits on the edge into DONE,
  // so tt already holds the new table during the done cycle.
  assign sweep_result = {gate_out, work_reg[14:0]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:   if (start && !abort) state_next = DRIVE;
      DRIVE:  if (abort) state_next = IDLE;
              else if (settle_cnt_reg == SETTLE_LAST) state_next = SAMPLE;
      SAMPLE: if (abort) state_next = IDLE;
              else if (vec == 4'd15) state_next = DONE;
              else state_next = DRIVE;
      DONE:   state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    busy = (state_reg != IDLE);
    done = (state_reg == DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vec            <= 4'd0;
      settle_cnt_reg <= 4'd0;
      work_reg       <= 16'h0000;
      tt             <= 16'h0000;
    end else begin
      case (state_reg)
        IDLE: begin
          if (state_next == DRIVE) begin
            vec            <= 4'd0;
            settle_cnt_reg <= 4'd0;
            work_reg       <= 16'h0000;
          end
        end
        DRIVE: begin
          if (state_next == DRIVE) settle_cnt_reg <= settle_cnt_reg + 4'd1;
          else if (state_next == IDLE) vec <= 4'd0;
        end
        SAMPLE: begin
          if (state_next == DRIVE) begin
            work_reg[vec]  <= gate_out;
            vec            <= vec + 4'd1;
            settle_cnt_reg <= 4'd0;
          end else if (state_next == DONE) begin
            work_reg <= sweep_result;
            tt       <= sweep_result;
          end else begin
            vec <= 4'd0;
          end
        end
        DONE: vec <= 4'd0;
        default: vec <= 4'd0;
      endcase
    end
  end

`ifdef TT_COMPARE_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) match <= 1'b0;
    else if (state_reg == SAMPLE && state_next == DONE)
      match <= (sweep_result == expect_tt);
  end
`endif

endmodule

// File: tb/tb_tt_capture.sv
// Directed bench for tt_capture: two instances (SETTLE=2 and SETTLE=1) driven
// by bench-side gate models; immediate assertions at every check point.
`timescale 1ns/1ps

module tb_tt_capture;
    logic        clk = 1'b0;
    logic        rst;
    logic        start, abort;
    logic [3:0]  vec;
    logic        gate_out, busy, done;
    logic [15:0] tt;
    logic        start1;
    logic [3:0]  vec1;
    logic        gate1, busy1, done1;
    logic [15:0] tt1;
    logic [15:0] gate_tt;
    logic        gate_sel, gate_const;
    int          errors = 0;
    int          checks = 0;
    int          lat, ndone, cnt;
    bit          vec_ok;
`ifdef TT_COMPARE_EN
    logic [15:0] expect_tt;
    logic        match, match1;
`endif

    always #5 clk = ~clk;

    assign gate_out = gate_sel ? gate_const : gate_tt[vec];

    tt_capture #(.SETTLE(2)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .vec(vec),
        .gate_out(gate_out), .busy(busy), .done(done), .tt(tt)
`ifdef TT_COMPARE_EN
        , .expect_tt(expect_tt), .match(match)
`endif
    );

    tt_capture #(.SETTLE(1)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .abort(1'b0), .vec(vec1),
        .gate_out(gate1), .busy(busy1), .done(done1), .tt(tt1)
`ifdef TT_COMPARE_EN
        , .expect_tt(16'h0000), .match(match1)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Start one sweep on the SETTLE=2 instance and watch 60 cycles after the
    // accepting edge; vec must read (c-1)/3 and busy must be high in cycles 1..48.
    task automatic sweep(input bit repulse, output int lat_o, output int nd_o, output bit ok_o);
        start = 1'b1;
        tick();
        start = 1'b0;
        lat_o = -1;
        nd_o  = 0;
        ok_o  = 1'b1;
        for (int c = 1; c <= 60; c++) begin
            if (c <= 48 && (vec !== 4'((c - 1) / 3) || busy !== 1'b1)) ok_o = 1'b0;
            if (done === 1'b1) begin
                nd_o++;
                if (lat_o < 0) lat_o = c;
            end
            start = (repulse && (c == 5 || c == 20)) ? 1'b1 : 1'b0;
            tick();
        end
        start = 1'b0;
        $display("sweep: latency=%0d done_pulses=%0d tt=%04h", lat_o, nd_o, tt);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; abort = 1'b0; start1 = 1'b0; gate1 = 1'b0;
        gate_tt = 16'hBDF1; gate_sel = 1'b0; gate_const = 1'b0;
`ifdef TT_COMPARE_EN
        expect_tt = 16'hBDF1;
`endif
        #12;
        chk("reset_vec", vec, 4'd0);
        chk("reset_busy", busy, 1'b0);
        chk("reset_done", done, 1'b0);
        chk("reset_tt", tt, 16'h0000);
`ifdef TT_COMPARE_EN
        chk("reset_match", match, 1'b0);
`endif
        rst = 1'b0;
        tick();

        sweep(1'b0, lat, ndone, vec_ok);
        chk("basic_latency", lat, 49);
        chk("basic_done_count", ndone, 1);
        chk("basic_vec_steps", vec_ok, 1'b1);
        chk("basic_tt", tt, 16'hBDF1);
        chk("basic_idle_busy", busy, 1'b0);
        chk("basic_idle_vec", vec, 4'd0);
`ifdef TT_COMPARE_EN
        chk("cmp_match_hit", match, 1'b1);
        expect_tt = 16'hBDF0;
        sweep(1'b0, lat, ndone, vec_ok);
        chk("cmp_match_miss", match, 1'b0);
`endif

        sweep(1'b1, lat, ndone, vec_ok);
        chk("repulse_latency", lat, 49);
        chk("repulse_done_count", ndone, 1);
        chk("repulse_tt", tt, 16'hBDF1);

        gate_sel = 1'b1; gate_const = 1'b1;
        start = 1'b1; tick(); start = 1'b0;
        cnt = 0;
        while (vec !== 4'd7 && cnt < 100) begin tick(); cnt++; end
        chk("abort_reach_vec7", vec, 4'd7);
        abort = 1'b1; tick(); abort = 1'b0;
        chk("abort_busy", busy, 1'b0);
        chk("abort_vec", vec, 4'd0);
        ndone = 0;
        for (int c = 0; c < 60; c++) begin
            if (done === 1'b1) ndone++;
            tick();
        end
        chk("abort_no_done", ndone, 0);
        chk("abort_tt_kept", tt, 16'hBDF1);
        $display("abort: busy=%0b tt=%04h", busy, tt);

        start = 1'b1; abort = 1'b1; tick(); start = 1'b0; abort = 1'b0;
        chk("start_abort_idle", busy, 1'b0);

        start = 1'b1; tick(); start = 1'b0;
        cnt = 0;
        while (vec !== 4'd10 && cnt < 100) begin tick(); cnt++; end
        chk("rst_reach_vec10", vec, 4'd10);
        #3 rst = 1'b1;
        #1;
        chk("rst_async_vec", vec, 4'd0);
        chk("rst_async_busy", busy, 1'b0);
        chk("rst_async_tt", tt, 16'h0000);
        chk("rst_async_done", done, 1'b0);
        #1 rst = 1'b0;
        tick();
        sweep(1'b0, lat, ndone, vec_ok);
        chk("post_rst_latency", lat, 49);
        chk("post_rst_done_count", ndone, 1);
        chk("post_rst_vec_steps", vec_ok, 1'b1);
        chk("post_rst_tt", tt, 16'hFFFF);

        for (int pass = 0; pass < 2; pass++) begin
            gate1 = (pass == 0) ? 1'b1 : 1'b0;
            start1 = 1'b1; tick(); start1 = 1'b0;
            lat = -1;
            for (int c = 1; c <= 40; c++) begin
                if (done1 === 1'b1 && lat < 0) lat = c;
                tick();
            end
            $display("settle1 sweep: gate=%0b latency=%0d tt=%04h", gate1, lat, tt1);
            chk("settle1_latency", lat, 33);
            chk("settle1_tt", tt1, (pass == 0) ? 16'hFFFF : 16'h0000);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
